// File: rtl/cpu_int_pkg.sv
// Shared types and constants for the CPU interrupt controller.
package cpu_int_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SVC,
    NMI_REQ,
    NMI_SVC
  } int_state_t;

  localparam logic [3:0] CAUSE_NMI = 4'hF;
  localparam int         N_IRQ_MAX = 15;

endpackage

// File: rtl/int_edge_latch.sv
// Purpose: one-bit rising-edge detector with sticky pend flag.
// Latency: edge in cycle t -> pend visible t+1.
// Backpressure: none; a new edge wins over a same-cycle clear.
module int_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic clr,
  output logic pend
);

  logic prev_q;
  logic rise;

  assign rise = din & ~prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      pend   <= 1'b0;
    end else begin
      prev_q <= din;
      pend   <= rise | (pend & ~clr);
    end
  end

endmodule

// File: rtl/int_controller.sv
// Purpose: capture, prioritise and present interrupts to the CPU at preFetch.
// Latency: boundary with eligible pend at edge t -> int_req from t+1.
// Backpressure: int_req held until int_ack; further requests stay pended.
module int_controller
  import cpu_int_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             nmi_in,
  input  logic             intd,
  input  logic             boundary,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             int_req,
  output logic             int_ina,
  output logic [3:0]       int_cause,
  output logic             in_service,
  output logic [N_IRQ:0]   pending
);

  int_state_t       state_q, state_d;
  logic [3:0]       cause_q, cause_d;
  logic [3:0]       saved_q, saved_d;
  logic             ina_q, ina_d;
  logic             nested_q, nested_d;
  logic [N_IRQ-1:0] mask_q;

  logic [N_IRQ-1:0] irq_pend;
  logic [N_IRQ-1:0] irq_clr;
  logic             nmi_pend;
  logic             nmi_clr;
  logic [N_IRQ-1:0] eligible;
  logic             any_elig;
  logic [3:0]       win_idx;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_irq
    int_edge_latch u_irq (
      .clk   (clk),
      .reset (reset),
      .din   (irq_in[g]),
      .clr   (irq_clr[g]),
      .pend  (irq_pend[g])
    );
  end

  int_edge_latch u_nmi (
    .clk   (clk),
    .reset (reset),
    .din   (nmi_in),
    .clr   (nmi_clr),
    .pend  (nmi_pend)
  );

  // Ack clears only the source that was latched when the request was raised.
  always_comb begin
    irq_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      irq_clr[i] = (state_q == REQ) && int_ack && (cause_q == 4'(i));
    end
  end

  assign nmi_clr = (state_q == NMI_REQ) && int_ack;

  assign eligible = irq_pend & ~mask_q & {N_IRQ{~intd}};
  assign any_elig = |eligible;

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    win_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cause_q  <= '0;
      saved_q  <= '0;
      ina_q    <= 1'b0;
      nested_q <= 1'b0;
      mask_q   <= '1;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      saved_q  <= saved_d;
      ina_q    <= ina_d;
      nested_q <= nested_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    saved_d  = saved_q;
    ina_d    = ina_q;
    nested_d = nested_q;
    case (state_q)
      IDLE: begin
        if (boundary && nmi_pend) begin
          state_d  = NMI_REQ;
          cause_d  = CAUSE_NMI;
          ina_d    = 1'b0;
          nested_d = 1'b0;
        end else if (boundary && any_elig) begin
          state_d = REQ;
          cause_d = win_idx;
          ina_d   = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = SVC;
        end
      end
      SVC: begin
        if (eoi) begin
          state_d = IDLE;
        end else if (boundary && nmi_pend) begin
          // Remember the interrupted maskable cause so it reappears on return.
          state_d  = NMI_REQ;
          nested_d = 1'b1;
          saved_d  = cause_q;
          cause_d  = CAUSE_NMI;
          ina_d    = 1'b0;
        end
      end
      NMI_REQ: begin
        if (int_ack) begin
          state_d = NMI_SVC;
        end
      end
      NMI_SVC: begin
        if (eoi) begin
          nested_d = 1'b0;
          if (nested_q) begin
            state_d = SVC;
            cause_d = saved_q;
            ina_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign int_req    = (state_q == REQ) || (state_q == NMI_REQ);
  assign in_service = (state_q == SVC) || (state_q == NMI_SVC);
  assign int_ina    = ina_q;
  assign int_cause  = cause_q;
  assign pending    = {nmi_pend, irq_pend};

endmodule

// File: tb/tb_int_controller.sv
// Directed stimulus with a queued scoreboard; a negedge monitor compares outputs.
module tb_int_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       nmi_in;
  logic       intd;
  logic       boundary;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       int_ack;
  logic       eoi;
  logic       int_req;
  logic       int_ina;
  logic [3:0] int_cause;
  logic       in_service;
  logic [4:0] pending;

  typedef struct {
    string      name;
    logic       req;
    logic       ina;
    logic [3:0] cause;
    logic       svc;
    logic [4:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int_controller #(.N_IRQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .nmi_in     (nmi_in),
    .intd       (intd),
    .boundary   (boundary),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .int_req    (int_req),
    .int_ina    (int_ina),
    .int_cause  (int_cause),
    .in_service (in_service),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic req, input logic ina,
                          input logic [3:0] cause, input logic svc, input logic [4:0] pend);
    exp_t e;
    e.name  = name;
    e.req   = req;
    e.ina   = ina;
    e.cause = cause;
    e.svc   = svc;
    e.pend  = pend;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (int_req !== e.req || int_ina !== e.ina || int_cause !== e.cause ||
          in_service !== e.svc || pending !== e.pend) begin
        errors++;
        $display("FAIL %s: got req=%0b ina=%0b cause=%0h svc=%0b pend=%b, want req=%0b ina=%0b cause=%0h svc=%0b pend=%b",
                 e.name, int_req, int_ina, int_cause, in_service, pending,
                 e.req, e.ina, e.cause, e.svc, e.pend);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; irq_in = '0; nmi_in = 1'b0; intd = 1'b0; boundary = 1'b0;
    mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    push_exp("reset", 0, 0, 4'h0, 0, 5'b00000);
    reset = 1'b0;
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;

    // Single source, full request/ack/eoi cycle.
    irq_in = 4'b0100; tick(); push_exp("t1_pend", 0, 0, 4'h0, 0, 5'b00100);
    irq_in = 4'b0000; boundary = 1'b1; tick(); push_exp("t1_req", 1, 1, 4'h2, 0, 5'b00100);
    boundary = 1'b0; int_ack = 1'b1; tick(); push_exp("t1_ack", 0, 1, 4'h2, 1, 5'b00000);
    int_ack = 1'b0; eoi = 1'b1; tick(); push_exp("t1_eoi", 0, 1, 4'h2, 0, 5'b00000);
    eoi = 1'b0;

    // Two sources at once: lower index first.
    irq_in = 4'b1010; tick(); push_exp("t2_pend", 0, 1, 4'h2, 0, 5'b01010);
    irq_in = 4'b0000; boundary = 1'b1; tick(); push_exp("t2_req1", 1, 1, 4'h1, 0, 5'b01010);
    boundary = 1'b0; int_ack = 1'b1; tick(); push_exp("t2_ack1", 0, 1, 4'h1, 1, 5'b01000);
    int_ack = 1'b0; eoi = 1'b1; tick(); push_exp("t2_eoi1", 0, 1, 4'h1, 0, 5'b01000);
    eoi = 1'b0; boundary = 1'b1; tick(); push_exp("t2_req3", 1, 1, 4'h3, 0, 5'b01000);
    boundary = 1'b0; int_ack = 1'b1; tick(); push_exp("t2_ack3", 0, 1, 4'h3, 1, 5'b00000);
    int_ack = 1'b0;

    // NMI nested over maskable service.
    nmi_in = 1'b1; tick(); push_exp("t3_npend", 0, 1, 4'h3, 1, 5'b10000);
    nmi_in = 1'b0; boundary = 1'b1; tick(); push_exp("t3_nreq", 1, 0, 4'hF, 0, 5'b10000);
    boundary = 1'b0; int_ack = 1'b1; tick(); push_exp("t3_nack", 0, 0, 4'hF, 1, 5'b00000);
    int_ack = 1'b0; eoi = 1'b1; tick(); push_exp("t3_neoi", 0, 1, 4'h3, 1, 5'b00000);
    tick(); push_exp("t3_eoi", 0, 1, 4'h3, 0, 5'b00000);
    eoi = 1'b0;

    // Masking holds off a pended source; unmasking releases it.
    mask_we = 1'b1; mask_wdata = 4'b0100; tick();
    mask_we = 1'b0; irq_in = 4'b0100; tick(); push_exp("t4_pend", 0, 1, 4'h3, 0, 5'b00100);
    irq_in = 4'b0000; boundary = 1'b1; tick(); push_exp("t4_masked", 0, 1, 4'h3, 0, 5'b00100);
    mask_we = 1'b1; mask_wdata = 4'b0000; tick(); push_exp("t4_unmask_edge", 0, 1, 4'h3, 0, 5'b00100);
    mask_we = 1'b0; tick(); push_exp("t4_req", 1, 1, 4'h2, 0, 5'b00100);
    boundary = 1'b0; int_ack = 1'b1; tick(); push_exp("t4_ack", 0, 1, 4'h2, 1, 5'b00000);
    int_ack = 1'b0; eoi = 1'b1; tick(); push_exp("t4_eoi", 0, 1, 4'h2, 0, 5'b00000);
    eoi = 1'b0;

    // intd blocks maskable but not NMI.
    intd = 1'b1; irq_in = 4'b0001; tick(); push_exp("t4_intd_pend", 0, 1, 4'h2, 0, 5'b00001);
    irq_in = 4'b0000; boundary = 1'b1; tick(); push_exp("t4_intd_blk", 0, 1, 4'h2, 0, 5'b00001);
    nmi_in = 1'b1; tick(); push_exp("t4_nmi_pend", 0, 1, 4'h2, 0, 5'b10001);
    nmi_in = 1'b0; tick(); push_exp("t4_nmi_req", 1, 0, 4'hF, 0, 5'b10001);
    boundary = 1'b0; int_ack = 1'b1; tick(); push_exp("t4_nmi_ack", 0, 0, 4'hF, 1, 5'b00001);
    int_ack = 1'b0; eoi = 1'b1; tick(); push_exp("t4_nmi_eoi", 0, 0, 4'hF, 0, 5'b00001);
    eoi = 1'b0; intd = 1'b0;

    // Request held with no ack; later mask change must not withdraw it.
    boundary = 1'b1; tick(); push_exp("t5_req", 1, 1, 4'h0, 0, 5'b00001);
    boundary = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mask_we = (i == 0 || i == 5) ? 1'b1 : 1'b0;
      mask_wdata = (i == 0) ? 4'b1111 : 4'b0000;
      tick(); push_exp("t5_hold", 1, 1, 4'h0, 0, 5'b00001);
    end
    mask_we = 1'b0;
    reset = 1'b1; tick(); push_exp("t5_reset", 0, 0, 4'h0, 0, 5'b00000);
    reset = 1'b0;
    irq_in = 4'b0001; tick(); push_exp("t5_rst_pend", 0, 0, 4'h0, 0, 5'b00001);
    irq_in = 4'b0000; boundary = 1'b1; tick(); push_exp("t5_rst_mask", 0, 0, 4'h0, 0, 5'b00001);
    boundary = 1'b0; mask_we = 1'b1; mask_wdata = 4'b0000; tick();
    mask_we = 1'b0;

    // New edge coincident with its ack-clear keeps the bit set.
    boundary = 1'b1; tick(); push_exp("t6_req", 1, 1, 4'h0, 0, 5'b00001);
    boundary = 1'b0; int_ack = 1'b1; irq_in = 4'b0001; tick();
    push_exp("t6_setclr", 0, 1, 4'h0, 1, 5'b00001);
    int_ack = 1'b0; irq_in = 4'b0000; eoi = 1'b1; tick(); push_exp("t6_eoi", 0, 1, 4'h0, 0, 5'b00001);

    // Stray ack/eoi in IDLE are ignored.
    int_ack = 1'b1; tick(); push_exp("stray_ack_eoi", 0, 1, 4'h0, 0, 5'b00001);
    int_ack = 1'b0; eoi = 1'b0;

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
